// File: rtl/mult_array_arbiter.sv
// Shares one LANES-wide multiplier bank between NREQ requesters: sticky round-robin issue,
// registered operands, and a LAT+1 deep tag pipeline that routes each product back to its issuer.
module mult_array_arbiter #(
    parameter int NREQ     = 3,
    parameter int LANES    = 15,
    parameter int WIDTH    = 27,
    parameter int LAT      = 5,
    parameter int MAXBURST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*LANES*WIDTH-1:0]   req_dataa,
    input  logic [NREQ*LANES*WIDTH-1:0]   req_datab,
    output logic [NREQ-1:0]               gnt,
    output logic [LANES*WIDTH-1:0]        array_mult_dataa,
    output logic [LANES*WIDTH-1:0]        array_mult_datab,
    input  logic [LANES*WIDTH-1:0]        array_mult_result,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [LANES*WIDTH-1:0]        rsp_data,
    output logic                          busy
);

    localparam int SETW = LANES * WIDTH;
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW   = $clog2(MAXBURST + 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAXBURST);

    logic [IW-1:0]   r_last;
    logic [BW-1:0]   r_burst;
    logic            r_stream;
    logic            w_found;
    logic            w_hold;
    logic            w_issue;
    logic            w_alone;
    logic [IW-1:0]   w_rr_idx;
    logic [IW-1:0]   w_sel;
    logic [SETW-1:0] w_opa;
    logic [SETW-1:0] w_opb;
    logic [SETW-1:0] r_opa;
    logic [SETW-1:0] r_opb;
    logic [SETW-1:0] r_rsp_data;
    logic [LAT:0]    r_tag_v;
    logic [IW-1:0]   r_tag_idx [LAT+1];
    logic [NREQ-1:0] r_rsp_valid;
    logic [NREQ-1:0] w_rsp_onehot;

    // A requester whose burst began uncontested keeps the bank until MAXBURST once
    // others show up; otherwise plain round-robin starting after the last grant.
    always_comb begin
        w_found  = 1'b0;
        w_rr_idx = r_last;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] && (IW'(i) > r_last)) begin
                w_found  = 1'b1;
                w_rr_idx = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] && (IW'(i) <= r_last)) begin
                w_found  = 1'b1;
                w_rr_idx = IW'(i);
            end
        end
        w_hold  = r_stream && req[r_last] && (r_burst < BURST_MAX);
        w_sel   = w_hold ? r_last : w_rr_idx;
        w_issue = en && !rst && (|req);
        w_alone = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (IW'(i) != w_sel)) begin
                w_alone = 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign gnt[gi]          = w_issue && (w_sel == IW'(gi));
        assign w_rsp_onehot[gi] = r_tag_v[LAT] && (r_tag_idx[LAT] == IW'(gi));
    end

    always_comb begin
        w_opa = '0;
        w_opb = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                w_opa = req_dataa[i*SETW +: SETW];
                w_opb = req_datab[i*SETW +: SETW];
            end
        end
    end

    // Arbiter state is frozen while en is low so a paused burst resumes its count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= LAST_INIT;
            r_burst  <= '0;
            r_stream <= 1'b0;
        end else if (en) begin
            if (w_issue) begin
                r_last <= w_sel;
                if (w_sel == r_last) begin
                    if (r_burst != BURST_MAX) begin
                        r_burst <= r_burst + 1'b1;
                    end
                    r_stream <= r_stream | w_alone;
                end else begin
                    r_burst  <= BW'(1);
                    r_stream <= w_alone;
                end
            end else begin
                r_burst  <= '0;
                r_stream <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa <= '0;
            r_opb <= '0;
        end else if (w_issue) begin
            r_opa <= w_opa;
            r_opb <= w_opb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_v <= '0;
            for (int k = 0; k <= LAT; k++) begin
                r_tag_idx[k] <= '0;
            end
        end else begin
            r_tag_v      <= {r_tag_v[LAT-1:0], w_issue};
            r_tag_idx[0] <= w_sel;
            for (int k = 1; k <= LAT; k++) begin
                r_tag_idx[k] <= r_tag_idx[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_rsp_onehot;
            if (r_tag_v[LAT]) begin
                r_rsp_data <= array_mult_result;
            end
        end
    end

    assign array_mult_dataa = r_opa;
    assign array_mult_datab = r_opb;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_data         = r_rsp_data;
    assign busy             = (|r_tag_v) | (|r_rsp_valid);

endmodule

// File: tb/tb_mult_array_arbiter.sv
// Directed bench for mult_array_arbiter: per-cycle vector tables plus hand-written
// sequences for reset, single issue and long back-to-back streams. Q16 multiplier model.
module tb_mult_array_arbiter;

    localparam int NREQ     = 3;
    localparam int LANES    = 15;
    localparam int WIDTH    = 27;
    localparam int LAT      = 5;
    localparam int MAXBURST = 4;
    localparam int SETW     = LANES * WIDTH;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic [NREQ-1:0]      req;
    logic [NREQ*SETW-1:0] req_dataa;
    logic [NREQ*SETW-1:0] req_datab;
    logic [NREQ-1:0]      gnt;
    logic [SETW-1:0]      array_mult_dataa;
    logic [SETW-1:0]      array_mult_datab;
    logic [SETW-1:0]      array_mult_result;
    logic [NREQ-1:0]      rsp_valid;
    logic [SETW-1:0]      rsp_data;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    mult_array_arbiter #(
        .NREQ(NREQ), .LANES(LANES), .WIDTH(WIDTH), .LAT(LAT), .MAXBURST(MAXBURST)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .req_dataa(req_dataa), .req_datab(req_datab), .gnt(gnt),
        .array_mult_dataa(array_mult_dataa), .array_mult_datab(array_mult_datab),
        .array_mult_result(array_mult_result), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SETW-1:0] mul_q16(input logic [SETW-1:0] a, input logic [SETW-1:0] b);
        logic [SETW-1:0]    r;
        logic [2*WIDTH-1:0] p;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            p = a[l*WIDTH +: WIDTH] * b[l*WIDTH +: WIDTH];
            r[l*WIDTH +: WIDTH] = p[16 +: WIDTH];
        end
        return r;
    endfunction

    // Multiplier bank: product of operands presented in cycle c appears in cycle c+LAT.
    logic [SETW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= mul_q16(array_mult_dataa, array_mult_datab);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign array_mult_result = mpipe[LAT-1];

    function automatic logic [SETW-1:0] fill(input logic [WIDTH-1:0] v);
        logic [SETW-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*WIDTH +: WIDTH] = v;
        return r;
    endfunction

    // r0: 1.5*2.0, r1: 2.5*(lane+1), r2: 0.5*4.0
    function automatic logic [SETW-1:0] opa(input int r);
        if (r == 0) return fill(27'h18000);
        if (r == 1) return fill(27'h28000);
        return fill(27'h08000);
    endfunction

    function automatic logic [SETW-1:0] opb(input int r);
        logic [SETW-1:0] v;
        if (r == 0) return fill(27'h20000);
        if (r == 2) return fill(27'h40000);
        for (int l = 0; l < LANES; l++) v[l*WIDTH +: WIDTH] = WIDTH'((l + 1) * 32'h10000);
        return v;
    endfunction

    function automatic logic [SETW-1:0] expv(input int r);
        logic [SETW-1:0] v;
        if (r == 0) return fill(27'h30000);
        if (r == 2) return fill(27'h20000);
        for (int l = 0; l < LANES; l++) v[l*WIDTH +: WIDTH] = WIDTH'((l + 1) * 32'h28000);
        return v;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        if (v[1]) return 1;
        if (v[2]) return 2;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [SETW-1:0] act, input logic [SETW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        en  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic            en;
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] gnt;
        logic [NREQ-1:0] rsp;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic e, input logic [NREQ-1:0] r,
                                input logic [NREQ-1:0] g, input logic [NREQ-1:0] v);
        vec_t t;
        t.en = e; t.req = r; t.gnt = g; t.rsp = v;
        vq.push_back(t);
    endfunction

    // Starts right after do_reset; rsp_data must hold the most recent response.
    task automatic run_table(input string tag);
        logic [SETW-1:0] hold;
        hold = '0;
        for (int c = 0; c < vq.size(); c++) begin
            en  = vq[c].en;
            req = vq[c].req;
            @(negedge clk);
            if (vq[c].rsp != '0) hold = expv(idx_of(vq[c].rsp));
            chk($sformatf("%s c%0d gnt", tag, c), SETW'(gnt), SETW'(vq[c].gnt));
            chk($sformatf("%s c%0d rsp_valid", tag, c), SETW'(rsp_valid), SETW'(vq[c].rsp));
            chk($sformatf("%s c%0d rsp_data", tag, c), rsp_data, hold);
            $display("%s c%0d en=%b req=%b gnt=%b rsp_valid=%b", tag, c, en, req, gnt, rsp_valid);
            tick();
        end
        vq.delete();
    endtask

    initial begin
        for (int r = 0; r < NREQ; r++) begin
            req_dataa[r*SETW +: SETW] = opa(r);
            req_datab[r*SETW +: SETW] = opb(r);
        end

        // reset state, with requests pending to show grants are held off
        rst = 1'b1; en = 1'b1; req = 3'b111;
        @(negedge clk);
        chk("reset gnt", SETW'(gnt), '0);
        chk("reset rsp_valid", SETW'(rsp_valid), '0);
        chk("reset busy", SETW'(busy), '0);
        chk("reset rsp_data", rsp_data, '0);
        chk("reset dataa", array_mult_dataa, '0);
        tick();
        rst = 1'b0;

        // single request, latency LAT+2
        req = 3'b001;
        @(negedge clk);
        chk("single c0 gnt", SETW'(gnt), SETW'(3'b001));
        chk("single c0 dataa", array_mult_dataa, '0);
        chk("single c0 busy", SETW'(busy), '0);
        tick();
        for (int c = 1; c <= 8; c++) begin
            req = 3'b000;
            @(negedge clk);
            chk($sformatf("single c%0d gnt", c), SETW'(gnt), '0);
            chk($sformatf("single c%0d rsp_valid", c), SETW'(rsp_valid), SETW'((c == 7) ? 3'b001 : 3'b000));
            chk($sformatf("single c%0d busy", c), SETW'(busy), SETW'(c <= 7));
            if (c == 1) begin
                chk("single c1 dataa", array_mult_dataa, opa(0));
                chk("single c1 datab", array_mult_datab, opb(0));
            end
            if (c == 7) chk("single c7 rsp_data", rsp_data, expv(0));
            if (c == 8) chk("single c8 dataa held", array_mult_dataa, opa(0));
            $display("single c%0d gnt=%b rsp_valid=%b busy=%b", c, gnt, rsp_valid, busy);
            tick();
        end

        // contention: strict rotation, responses in issue order
        do_reset();
        add(1, 3'b111, 3'b001, 3'b000); add(1, 3'b111, 3'b010, 3'b000);
        add(1, 3'b111, 3'b100, 3'b000); add(1, 3'b111, 3'b001, 3'b000);
        add(1, 3'b111, 3'b010, 3'b000); add(1, 3'b111, 3'b100, 3'b000);
        add(1, 3'b000, 3'b000, 3'b000); add(1, 3'b000, 3'b000, 3'b001);
        add(1, 3'b000, 3'b000, 3'b010); add(1, 3'b000, 3'b000, 3'b100);
        add(1, 3'b000, 3'b000, 3'b001); add(1, 3'b000, 3'b000, 3'b010);
        add(1, 3'b000, 3'b000, 3'b100); add(1, 3'b000, 3'b000, 3'b000);
        run_table("rr");

        // burst fairness
        do_reset();
        add(1, 3'b001, 3'b001, 3'b000); add(1, 3'b001, 3'b001, 3'b000);
        add(1, 3'b011, 3'b001, 3'b000); add(1, 3'b011, 3'b001, 3'b000);
        add(1, 3'b011, 3'b010, 3'b000); add(1, 3'b001, 3'b001, 3'b000);
        add(1, 3'b001, 3'b001, 3'b000); add(1, 3'b001, 3'b001, 3'b001);
        add(1, 3'b001, 3'b001, 3'b001); add(1, 3'b001, 3'b001, 3'b001);
        add(1, 3'b000, 3'b000, 3'b001); add(1, 3'b000, 3'b000, 3'b010);
        for (int i = 0; i < 5; i++) add(1, 3'b000, 3'b000, 3'b001);
        add(1, 3'b000, 3'b000, 3'b000);
        run_table("burst");

        // en low mid-stream: no grants, in-flight responses still arrive
        do_reset();
        add(1, 3'b011, 3'b001, 3'b000); add(1, 3'b011, 3'b010, 3'b000);
        add(1, 3'b011, 3'b001, 3'b000);
        for (int i = 0; i < 3; i++) add(0, 3'b011, 3'b000, 3'b000);
        add(1, 3'b011, 3'b010, 3'b000); add(1, 3'b011, 3'b001, 3'b001);
        add(1, 3'b000, 3'b000, 3'b010); add(1, 3'b000, 3'b000, 3'b001);
        for (int i = 0; i < 3; i++) add(1, 3'b000, 3'b000, 3'b000);
        add(1, 3'b000, 3'b000, 3'b010); add(1, 3'b000, 3'b000, 3'b001);
        add(1, 3'b000, 3'b000, 3'b000);
        run_table("enlow");

        // en low freezes the burst count; resume continues it
        do_reset();
        add(1, 3'b001, 3'b001, 3'b000); add(1, 3'b001, 3'b001, 3'b000);
        add(0, 3'b011, 3'b000, 3'b000); add(0, 3'b011, 3'b000, 3'b000);
        add(1, 3'b011, 3'b001, 3'b000); add(1, 3'b011, 3'b001, 3'b000);
        add(1, 3'b011, 3'b010, 3'b000); add(1, 3'b001, 3'b001, 3'b001);
        add(1, 3'b000, 3'b000, 3'b001); add(1, 3'b000, 3'b000, 3'b000);
        add(1, 3'b000, 3'b000, 3'b000); add(1, 3'b000, 3'b000, 3'b001);
        add(1, 3'b000, 3'b000, 3'b001); add(1, 3'b000, 3'b000, 3'b010);
        add(1, 3'b000, 3'b000, 3'b001); add(1, 3'b000, 3'b000, 3'b000);
        run_table("freeze");

        // 20 back-to-back issues from one requester
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            req = (c < 20) ? 3'b001 : 3'b000;
            @(negedge clk);
            chk($sformatf("b2b c%0d gnt", c), SETW'(gnt), SETW'((c < 20) ? 3'b001 : 3'b000));
            chk($sformatf("b2b c%0d rsp_valid", c), SETW'(rsp_valid),
                SETW'((c >= 7 && c <= 26) ? 3'b001 : 3'b000));
            chk($sformatf("b2b c%0d busy", c), SETW'(busy), SETW'(c >= 1 && c <= 26));
            if (c == 26) chk("b2b c26 rsp_data", rsp_data, expv(0));
            $display("b2b c%0d gnt=%b rsp_valid=%b busy=%b", c, gnt, rsp_valid, busy);
            tick();
        end

        // reset mid-operation discards in-flight work
        for (int c = 0; c < 4; c++) begin
            req = 3'b001;
            @(negedge clk);
            chk($sformatf("midrst c%0d gnt", c), SETW'(gnt), SETW'(3'b001));
            tick();
        end
        rst = 1'b1; req = 3'b111; en = 1'b1;
        @(negedge clk);
        chk("midrst in-reset gnt", SETW'(gnt), '0);
        chk("midrst in-reset rsp_valid", SETW'(rsp_valid), '0);
        chk("midrst in-reset busy", SETW'(busy), '0);
        chk("midrst in-reset rsp_data", rsp_data, '0);
        chk("midrst in-reset dataa", array_mult_dataa, '0);
        $display("midrst reset asserted busy=%b rsp_valid=%b", busy, rsp_valid);
        tick();
        rst = 1'b0;
        req = 3'b111;
        @(negedge clk);
        chk("midrst p0 first gnt", SETW'(gnt), SETW'(3'b001));
        tick();
        for (int p = 1; p <= 10; p++) begin
            req = 3'b000;
            @(negedge clk);
            chk($sformatf("midrst p%0d rsp_valid", p), SETW'(rsp_valid), SETW'((p == 7) ? 3'b001 : 3'b000));
            chk($sformatf("midrst p%0d busy", p), SETW'(busy), SETW'(p <= 7));
            $display("midrst p%0d rsp_valid=%b busy=%b", p, rsp_valid, busy);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
